// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer: source of the 8-bit interrupt vector sampled by CP0 Cause.IP[7:0].
//   Implements CP0 Count (reg 9) and Compare (reg 11), the sticky timer-pending flag,
//   the two software-interrupt bits (Cause reg 13, wdata[9:8]), and synchronization of
//   five asynchronous external IRQ lines with optional per-line rising-edge capture.
//
// Ports:
//   clk           core clock
//   reset         synchronous, active-low reset
//   count_enable  1 = prescaler/Count advance; 0 = frozen (writes still work)
//   cp0_we        mtc0 write strobe
//   cp0_waddr     CP0 register number for the write
//   cp0_wdata     write data
//   cp0_raddr     CP0 register number for the read
//   cp0_rdata     combinational read: Count (9), Compare (11), else 0
//   irq_in        asynchronous external interrupt lines
//   irq_ack       one-cycle clear of latched edge lines (ignored for level lines)
//   interrupts    registered vector: [1:0] SW, [6:2] HW, [7] timer pending
//   timer_pending alias of interrupts[7]

module cp0_irq_timer #(
  parameter int unsigned COUNT_DIV = 2,        // core cycles per Count increment, 1..255
  parameter logic [4:0]  EDGE_MASK = 5'b00000  // 1 = rising-edge latched, 0 = level
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_enable,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic [4:0]  irq_in,
  input  logic [4:0]  irq_ack,
  output logic [7:0]  interrupts,
  output logic        timer_pending
);

  localparam logic [4:0] RegCount   = 5'd9;
  localparam logic [4:0] RegCompare = 5'd11;
  localparam logic [4:0] RegCause   = 5'd13;

  localparam logic [7:0] PrescMax = 8'(COUNT_DIV - 1);

  // State
  logic [7:0]  presc_q,   presc_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q,    pend_d;
  logic [1:0]  sw_ip_q,   sw_ip_d;
  logic [4:0]  s1_q, s2_q, s3_q;
  logic [4:0]  latch_q,   latch_d;
  logic [6:0]  vec_q,     vec_d;   // interrupts[6:0]; bit 7 is pend_q directly

  // Write decode
  logic wr_count, wr_compare, wr_cause;
  logic tick;
  logic [31:0] count_inc;
  logic [4:0]  rise;
  logic [4:0]  hw_next;

  always_comb begin
    wr_count   = cp0_we && (cp0_waddr == RegCount);
    wr_compare = cp0_we && (cp0_waddr == RegCompare);
    wr_cause   = cp0_we && (cp0_waddr == RegCause);
  end

  // Prescaler and Count
  always_comb begin
    tick      = count_enable && (presc_q == PrescMax);
    count_inc = count_q + 32'd1;

    presc_d = presc_q;
    if (wr_count) begin
      presc_d = 8'd0;
    end else if (count_enable) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end

    count_d = count_q;
    if (wr_count) begin
      count_d = cp0_wdata;
    end else if (tick) begin
      count_d = count_inc;
    end
  end

  // Compare and timer pending. Pending is set only by a tick that steps Count into
  // equality with the Compare value held before this edge; a Compare write always wins.
  always_comb begin
    compare_d = compare_q;
    if (wr_compare) begin
      compare_d = cp0_wdata;
    end

    pend_d = pend_q;
    if (wr_compare) begin
      pend_d = 1'b0;
    end else if (tick && !wr_count && (count_inc == compare_q)) begin
      pend_d = 1'b1;
    end
  end

  // Software interrupt bits
  always_comb begin
    sw_ip_d = sw_ip_q;
    if (wr_cause) begin
      sw_ip_d = cp0_wdata[9:8];
    end
  end

  // External IRQ lines: edge lines latch on a synchronized rising edge; a new edge in
  // the same cycle as an ack keeps the latch set.
  always_comb begin
    rise    = s2_q & ~s3_q;
    latch_d = EDGE_MASK & (rise | (latch_q & ~irq_ack));
    hw_next = (EDGE_MASK & latch_d) | (~EDGE_MASK & s2_q);
    vec_d   = {hw_next, sw_ip_d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q   <= 8'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pend_q    <= 1'b0;
      sw_ip_q   <= 2'b00;
      s1_q      <= 5'd0;
      s2_q      <= 5'd0;
      s3_q      <= 5'd0;
      latch_q   <= 5'd0;
      vec_q     <= 7'd0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
      sw_ip_q   <= sw_ip_d;
      s1_q      <= irq_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      latch_q   <= latch_d;
      vec_q     <= vec_d;
    end
  end

  // Read port shows contents before the current edge.
  always_comb begin
    cp0_rdata = 32'd0;
    if (cp0_raddr == RegCount) begin
      cp0_rdata = count_q;
    end else if (cp0_raddr == RegCompare) begin
      cp0_rdata = compare_q;
    end
  end

  assign interrupts    = {pend_q, vec_q};
  assign timer_pending = pend_q;

endmodule

// File: tb/tb_cp0_irq_timer.sv
module tb_cp0_irq_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        count_enable;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [4:0]  irq_in;
  logic [4:0]  irq_ack;

  logic [31:0] rdata_l, rdata_e;
  logic [7:0]  int_l, int_e;
  logic        tp_l, tp_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_irq_timer #(.COUNT_DIV(2), .EDGE_MASK(5'b00000)) dut_lvl (
    .clk(clk), .reset(reset), .count_enable(count_enable), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
    .cp0_rdata(rdata_l), .irq_in(irq_in), .irq_ack(irq_ack),
    .interrupts(int_l), .timer_pending(tp_l)
  );

  cp0_irq_timer #(.COUNT_DIV(2), .EDGE_MASK(5'b00001)) dut_edg (
    .clk(clk), .reset(reset), .count_enable(count_enable), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
    .cp0_rdata(rdata_e), .irq_in(irq_in), .irq_ack(irq_ack),
    .interrupts(int_e), .timer_pending(tp_e)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cp0_write(input logic [4:0] addr, input logic [31:0] data);
    cp0_we    = 1'b1;
    cp0_waddr = addr;
    cp0_wdata = data;
    step(1);
    cp0_we    = 1'b0;
  endtask

  task automatic pulse0();
    irq_in[0] = 1'b1;
    step(1);
    irq_in[0] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    cp0_raddr = 5'd9;
    #1;
    total++;
    if (int_l !== 8'h00 || int_e !== 8'h00) begin
      bad++; $display("FAIL reset_irq: got %h/%h want 00", int_l, int_e);
    end
    total++;
    if (rdata_l !== 32'd0 || tp_l !== 1'b0) begin
      bad++; $display("FAIL reset_count: got %h tp=%b want 0 tp=0", rdata_l, tp_l);
    end
  endtask

  task automatic test_count();
    reset = 1'b1;
    step(10);
    cp0_raddr = 5'd9;
    #1;
    total++;
    if (rdata_l !== 32'd5) begin
      bad++; $display("FAIL count_10: got %0d want 5", rdata_l);
    end
    total++;
    if (int_l !== 8'h00) begin
      bad++; $display("FAIL count_irq: got %h want 00", int_l);
    end
  endtask

  task automatic test_timer();
    cp0_write(5'd11, 32'd3);
    cp0_write(5'd9, 32'd0);
    step(5);
    total++;
    if (tp_l !== 1'b0) begin
      bad++; $display("FAIL timer_early: got %b want 0", tp_l);
    end
    step(1);
    cp0_raddr = 5'd9;
    #1;
    total++;
    if (tp_l !== 1'b1 || int_l[7] !== 1'b1 || rdata_l !== 32'd3) begin
      bad++; $display("FAIL timer_set: got tp=%b cnt=%0d want tp=1 cnt=3", tp_l, rdata_l);
    end
    step(4);
    total++;
    if (tp_l !== 1'b1 || rdata_l !== 32'd5) begin
      bad++; $display("FAIL timer_sticky: got tp=%b cnt=%0d want tp=1 cnt=5", tp_l, rdata_l);
    end
    cp0_write(5'd11, 32'd100);
    cp0_raddr = 5'd11;
    #1;
    total++;
    if (tp_l !== 1'b0 || rdata_l !== 32'd100) begin
      bad++; $display("FAIL timer_clear: got tp=%b cmp=%0d want tp=0 cmp=100", tp_l, rdata_l);
    end
  endtask

  task automatic test_wrap();
    cp0_write(5'd11, 32'd0);
    cp0_write(5'd9, 32'hFFFF_FFFE);
    cp0_raddr = 5'd9;
    step(2);
    total++;
    if (rdata_l !== 32'hFFFF_FFFF || tp_l !== 1'b0) begin
      bad++; $display("FAIL wrap_ff: got cnt=%h tp=%b want ffffffff tp=0", rdata_l, tp_l);
    end
    step(2);
    total++;
    if (rdata_l !== 32'd0 || tp_l !== 1'b1) begin
      bad++; $display("FAIL wrap_zero: got cnt=%h tp=%b want 0 tp=1", rdata_l, tp_l);
    end
    // Compare write on the match cycle must win.
    cp0_write(5'd11, 32'd0);
    cp0_write(5'd9, 32'hFFFF_FFFE);
    step(3);
    cp0_write(5'd11, 32'd0);
    total++;
    if (rdata_l !== 32'd0 || tp_l !== 1'b0) begin
      bad++; $display("FAIL wrap_cmpwr: got cnt=%h tp=%b want 0 tp=0", rdata_l, tp_l);
    end
    step(2);
    total++;
    if (tp_l !== 1'b0) begin
      bad++; $display("FAIL wrap_cmpwr_hold: got %b want 0", tp_l);
    end
  endtask

  task automatic test_level();
    irq_in = 5'b00100;
    step(2);
    total++;
    if (int_l !== 8'h00) begin
      bad++; $display("FAIL level_early: got %h want 00", int_l);
    end
    step(1);
    total++;
    if (int_l !== 8'h10 || int_e !== 8'h10) begin
      bad++; $display("FAIL level_set: got %h/%h want 10", int_l, int_e);
    end
    irq_in = 5'b00000;
    step(2);
    total++;
    if (int_l !== 8'h10) begin
      bad++; $display("FAIL level_hold: got %h want 10", int_l);
    end
    step(1);
    total++;
    if (int_l !== 8'h00) begin
      bad++; $display("FAIL level_drop: got %h want 00", int_l);
    end
  endtask

  task automatic test_edge();
    pulse0();
    step(1);
    total++;
    if (int_e !== 8'h00) begin
      bad++; $display("FAIL edge_early: got %h want 00", int_e);
    end
    step(1);
    total++;
    if (int_e !== 8'h04 || int_l !== 8'h04) begin
      bad++; $display("FAIL edge_set: got %h/%h want 04/04", int_e, int_l);
    end
    step(5);
    total++;
    if (int_e !== 8'h04 || int_l !== 8'h00) begin
      bad++; $display("FAIL edge_hold: got %h/%h want 04/00", int_e, int_l);
    end
    irq_ack = 5'b00001;
    step(1);
    irq_ack = 5'b00000;
    total++;
    if (int_e !== 8'h00) begin
      bad++; $display("FAIL edge_ack: got %h want 00", int_e);
    end
    // Latch, then a second edge arriving with the ack keeps it set.
    pulse0();
    step(2);
    pulse0();
    step(1);
    irq_ack = 5'b00001;
    step(1);
    irq_ack = 5'b00000;
    total++;
    if (int_e !== 8'h04) begin
      bad++; $display("FAIL edge_ack_race: got %h want 04", int_e);
    end
    irq_ack = 5'b00001;
    step(1);
    irq_ack = 5'b00000;
    total++;
    if (int_e !== 8'h00) begin
      bad++; $display("FAIL edge_ack2: got %h want 00", int_e);
    end
  endtask

  task automatic test_sw_rw();
    cp0_write(5'd13, 32'h0000_0300);
    total++;
    if (int_l !== 8'h03) begin
      bad++; $display("FAIL sw_ip: got %h want 03", int_l);
    end
    cp0_write(5'd9, 32'h50);
    cp0_raddr = 5'd9;
    cp0_we    = 1'b1;
    cp0_waddr = 5'd9;
    cp0_wdata = 32'h77;
    #1;
    total++;
    if (rdata_l !== 32'h50) begin
      bad++; $display("FAIL rw_old: got %h want 50", rdata_l);
    end
    step(1);
    cp0_we = 1'b0;
    total++;
    if (rdata_l !== 32'h77) begin
      bad++; $display("FAIL rw_new: got %h want 77", rdata_l);
    end
    cp0_raddr = 5'd5;
    #1;
    total++;
    if (rdata_l !== 32'd0) begin
      bad++; $display("FAIL rd_other: got %h want 0", rdata_l);
    end
  endtask

  task automatic test_enable();
    count_enable = 1'b0;
    cp0_write(5'd9, 32'h40);
    step(6);
    cp0_raddr = 5'd9;
    #1;
    total++;
    if (rdata_l !== 32'h40) begin
      bad++; $display("FAIL en_freeze: got %h want 40", rdata_l);
    end
    cp0_write(5'd11, 32'h99);
    cp0_raddr = 5'd11;
    #1;
    total++;
    if (rdata_l !== 32'h99) begin
      bad++; $display("FAIL en_write: got %h want 99", rdata_l);
    end
    count_enable = 1'b1;
    step(2);
    cp0_raddr = 5'd9;
    #1;
    total++;
    if (rdata_l !== 32'h41) begin
      bad++; $display("FAIL en_resume: got %h want 41", rdata_l);
    end
  endtask

  task automatic test_midreset();
    pulse0();
    step(2);
    cp0_write(5'd11, 32'h10);
    cp0_write(5'd9, 32'h0F);
    step(2);
    total++;
    if (int_e !== 8'h87 || int_l !== 8'h83) begin
      bad++; $display("FAIL pre_reset: got %h/%h want 87/83", int_e, int_l);
    end
    irq_in = 5'b11111;
    reset  = 1'b0;
    step(1);
    irq_in = 5'b00000;
    total++;
    if (int_e !== 8'h00 || int_l !== 8'h00 || tp_e !== 1'b0 || tp_l !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got %h/%h tp=%b/%b want 00/00", int_e, int_l, tp_e, tp_l);
    end
    cp0_raddr = 5'd11;
    #1;
    total++;
    if (rdata_e !== 32'd0) begin
      bad++; $display("FAIL mid_reset_cmp: got %h want 0", rdata_e);
    end
    reset = 1'b1;
    step(4);
    total++;
    if (int_e !== 8'h00 || int_l !== 8'h00) begin
      bad++; $display("FAIL reset_flush: got %h/%h want 00/00", int_e, int_l);
    end
  endtask

  initial begin
    reset        = 1'b0;
    count_enable = 1'b1;
    cp0_we       = 1'b0;
    cp0_waddr    = 5'd0;
    cp0_wdata    = 32'd0;
    cp0_raddr    = 5'd0;
    irq_in       = 5'd0;
    irq_ack      = 5'd0;
    test_reset();
    test_count();
    test_timer();
    test_wrap();
    test_level();
    test_edge();
    test_sw_rw();
    test_enable();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
